// File: rtl/pow2_interp_pipe.sv
// Pipelined fractional power-of-two: out = round((2^f - 1) * 2^OUT) from a guarded
// 2^LUT_BITS+1 entry table with linear interpolation, elastic valid/ready, tag sideband.
module pow2_interp_pipe #(
   parameter int IN       = 8,
   parameter int OUT      = 9,
   parameter int LUT_BITS = 4,
   parameter int TAG_W    = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN-1:0]    in_frac,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT-1:0]   out_frac,
   output logic [TAG_W-1:0] out_tag
);

   localparam int R   = IN - LUT_BITS;
   localparam int RW  = (R > 0) ? R : 1;
   localparam int N   = 1 << LUT_BITS;
   localparam int TW  = OUT + 3;
   localparam int AW  = OUT + 3 + R + 1;
   localparam int NR  = 1 << R;

   if (LUT_BITS > IN || LUT_BITS < 1 || LUT_BITS > 10 || OUT > 24) begin : g_bad_cfg
      $fatal(1, "pow2_interp_pipe: unsupported IN/OUT/LUT_BITS combination");
   end

   typedef logic [N:0][TW-1:0] tab_t;

   // Two guard bits below the output LSB keep interpolation error under half an LSB.
   function automatic tab_t build_tab();
      tab_t t;
      real  v;
      for (int k = 0; k <= N; k++) begin
         v    = (2.0 ** (real'(k) / real'(N)) - 1.0) * (2.0 ** real'(OUT + 2));
         t[k] = TW'($rtoi(v + 0.5));
      end
      return t;
   endfunction

   localparam tab_t TAB = build_tab();

   function automatic logic [OUT-1:0] round_sat(input logic [AW-1:0] a);
      logic [AW:0] s;
      logic [AW:0] q;
      s = (AW+1)'(a) + (AW+1)'(2 ** (R + 1));
      q = s >> (R + 2);
      if (q > (AW+1)'((2 ** OUT) - 1))
         return '1;
      return q[OUT-1:0];
   endfunction

   logic [LUT_BITS:0] k_lo;
   logic [LUT_BITS:0] k_hi;
   logic [RW-1:0]     r_in;

   assign k_lo = {1'b0, in_frac[IN-1:R]};
   assign k_hi = k_lo + 1'b1;

   if (R > 0) begin : g_rem
      assign r_in = in_frac[RW-1:0];
   end else begin : g_norem
      assign r_in = '0;
   end

   logic             vld_p1, vld_p2, vld_p3;
   logic             ld_p1, ld_p2, ld_p3;
   logic [TW-1:0]    tlo_p1, thi_p1;
   logic [RW-1:0]    r_p1;
   logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3;
   logic [AW-1:0]    acc_p2;
   logic [AW-1:0]    acc_d;
   logic [OUT-1:0]   frac_p3;

   assign ld_p3    = !vld_p3 || out_ready;
   assign ld_p2    = !vld_p2 || ld_p3;
   assign ld_p1    = !vld_p1 || ld_p2;
   assign in_ready = !reset && ld_p1;

   assign acc_d = AW'(tlo_p1) * (AW'(NR) - AW'(r_p1)) + AW'(thi_p1) * AW'(r_p1);

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         vld_p3  <= 1'b0;
         frac_p3 <= '0;
         tag_p3  <= '0;
      end else begin
         if (ld_p1)
            vld_p1 <= in_valid;
         if (ld_p2)
            vld_p2 <= vld_p1;
         if (ld_p3) begin
            vld_p3 <= vld_p2;
            // S3: round, saturate and present
            if (vld_p2) begin
               frac_p3 <= round_sat(acc_p2);
               tag_p3  <= tag_p2;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      // S1: table fetch for both interpolation endpoints
      if (ld_p1 && in_valid) begin
         tlo_p1 <= TAB[k_lo];
         thi_p1 <= TAB[k_hi];
         r_p1   <= r_in;
         tag_p1 <= in_tag;
      end
      // S2: weighted sum of the endpoints
      if (ld_p2 && vld_p1) begin
         acc_p2 <= acc_d;
         tag_p2 <= tag_p1;
      end
   end

   assign out_valid = vld_p3;
   assign out_frac  = frac_p3;
   assign out_tag   = tag_p3;

endmodule

// File: tb/tb_pow2_interp_pipe.sv
// Directed + randomized bench for pow2_interp_pipe (OUT=9 and OUT=5 instances sharing inputs)
// against an arithmetic reference model and an in-order scoreboard.
module tb_pow2_interp_pipe;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_frac;
   logic [0:0] in_tag;
   logic       out_ready;
   logic       in_ready,  in_ready5;
   logic       out_valid, out_valid5;
   logic [8:0] out_frac;
   logic [4:0] out_frac5;
   logic [0:0] out_tag,   out_tag5;

   pow2_interp_pipe #(.IN(8), .OUT(9), .LUT_BITS(4), .TAG_W(1)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_frac(in_frac), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_frac(out_frac), .out_tag(out_tag));

   pow2_interp_pipe #(.IN(8), .OUT(5), .LUT_BITS(4), .TAG_W(1)) dut5 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready5),
      .in_frac(in_frac), .in_tag(in_tag), .out_valid(out_valid5), .out_ready(out_ready),
      .out_frac(out_frac5), .out_tag(out_tag5));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      int f9;
      int f5;
      int tag;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int   got9[$];
   int   got5[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc_n  = 0;
   bit   lat_mode = 0;
   bit   mono_mode = 0;
   int   last_frac = 0;
   bit   hold_chk = 0;
   logic [8:0] hold_frac;
   logic [0:0] hold_tag;

   // Ideal table entry: round((2^(k/16) - 1) * 2^(ow+2))
   function automatic int tbl(input int k, input int ow);
      return $rtoi((2.0 ** (real'(k) / 16.0) - 1.0) * (2.0 ** (ow + 2)) + 0.5);
   endfunction

   function automatic int model(input int f, input int ow);
      int k, r, acc, res, mx;
      k   = f / 16;
      r   = f % 16;
      acc = tbl(k, ow) * (16 - r) + tbl(k + 1, ow) * r;
      res = (acc + 32) / 64;
      mx  = (1 << ow) - 1;
      return (res > mx) ? mx : res;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, exp_v);
      end
   endtask

   task automatic cyc(input bit v, input logic [7:0] f, input logic t, input bit ordy,
                      output bit accd);
      exp_t e;
      in_valid  = v;
      in_frac   = f;
      in_tag    = t;
      out_ready = ordy;
      #1;
      accd = 1'b0;
      if (!reset) begin
         if (hold_chk) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_frac", 32'(out_frac), 32'(hold_frac));
            chk("hold_tag", 32'(out_tag), 32'(hold_tag));
         end
         if (in_valid)
            chk("in_ready_match", 32'(in_ready5), 32'(in_ready));
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_out", 32'(out_valid), 0);
            end else begin
               e = sbq.pop_front();
               chk("out_frac", 32'(out_frac), e.f9);
               chk("out_tag", 32'(out_tag), e.tag);
               chk("out_valid5", 32'(out_valid5), 1);
               chk("out_frac5", 32'(out_frac5), e.f5);
               chk("out_tag5", 32'(out_tag5), e.tag);
               if (lat_mode)
                  chk("latency", cyc_n - e.cyc, 3);
               if (mono_mode) begin
                  chk("monotonic", 32'(int'(out_frac) >= last_frac), 1);
                  last_frac = int'(out_frac);
               end
               got9.push_back(int'(out_frac));
               got5.push_back(int'(out_frac5));
            end
         end
         if (in_valid && in_ready) begin
            e.f9  = model(int'(in_frac), 9);
            e.f5  = model(int'(in_frac), 5);
            e.tag = int'(in_tag);
            e.cyc = cyc_n;
            sbq.push_back(e);
            accd = 1'b1;
         end
         hold_chk  = out_valid && !out_ready;
         hold_frac = out_frac;
         hold_tag  = out_tag;
      end else begin
         hold_chk = 1'b0;
      end
      @(posedge clock);
      #1;
      cyc_n++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         a;
      int         j;
      int         n0;
      int         guard;
      logic [7:0] fr [5];

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_frac   = 8'h00;
      in_tag    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);
      chk("post_rst_out_valid", 32'(out_valid), 0);
      chk("post_rst_out_frac", 32'(out_frac), 0);
      chk("post_rst_out_tag", 32'(out_tag), 0);
      chk("post_rst_out_frac5", 32'(out_frac5), 0);

      // Known points: 0 -> 0, 0.5 -> 212, 0xFF -> 509; OUT=5 saturates 0xFF to 31
      lat_mode = 1'b1;
      cyc(1'b1, 8'h00, 1'b1, 1'b1, a);
      cyc(1'b1, 8'h80, 1'b0, 1'b1, a);
      cyc(1'b1, 8'hFF, 1'b1, 1'b1, a);
      repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b1, a);
      chk("t1_count", got9.size(), 3);
      if (got9.size() == 3) begin
         chk("t1_zero", got9[0], 0);
         chk("t1_half", got9[1], 212);
         chk("t2_ff", got9[2], 509);
         chk("t3_sat5", got5[2], 31);
      end

      // Full sweep back-to-back
      got9.delete();
      got5.delete();
      mono_mode = 1'b1;
      last_frac = 0;
      for (int i = 0; i < 256; i++) begin
         cyc(1'b1, 8'(i), 1'($urandom), 1'b1, a);
         chk("stream_accept", 32'(a), 1);
      end
      repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b1, a);
      chk("stream_count", got9.size(), 256);
      mono_mode = 1'b0;
      lat_mode  = 1'b0;

      // Backpressure: 5 offered beats, 3 fit
      for (int i = 0; i < 5; i++) fr[i] = 8'($urandom);
      n0 = got9.size();
      j  = 0;
      repeat (6) begin
         cyc(1'b1, fr[j], 1'(j), 1'b0, a);
         if (a) j++;
      end
      chk("stall_accepted", j, 3);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      guard = 0;
      while ((j < 5 || sbq.size() != 0) && guard < 40) begin
         cyc(j < 5, fr[(j < 5) ? j : 0], 1'(j), 1'b1, a);
         if (a) j++;
         guard++;
      end
      chk("stall_drain_timeout", 32'(guard < 40), 1);
      chk("stall_all_accepted", j, 5);
      chk("stall_delivered", got9.size() - n0, 5);

      // Random traffic with random backpressure
      repeat (1500) begin
         cyc(($urandom % 4) != 0, 8'($urandom), 1'($urandom), ($urandom % 10) < 7, a);
      end
      guard = 0;
      while (sbq.size() != 0 && guard < 20) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b1, a);
         guard++;
      end
      chk("rand_drain_timeout", 32'(guard < 20), 1);

      // Reset with a full pipe discards everything
      j     = 0;
      guard = 0;
      while (j < 3 && guard < 10) begin
         cyc(1'b1, 8'($urandom), 1'b1, 1'b0, a);
         if (a) j++;
         guard++;
      end
      chk("t6_full", j, 3);
      n0    = got9.size();
      reset = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, a);
      chk("t6_out_valid", 32'(out_valid), 0);
      chk("t6_in_ready", 32'(in_ready), 0);
      chk("t6_out_frac", 32'(out_frac), 0);
      sbq.delete();
      reset = 1'b0;
      repeat (6) cyc(1'b0, 8'h00, 1'b0, 1'b1, a);
      chk("t6_none_delivered", got9.size(), n0);
      chk("t6_in_ready_after", 32'(in_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
